pixel_writer: RTL and testbench

Framebuffer-side consumer of the pixel stream produced by the line-drawing engine. It accepts (x, y, colour) pixels over a valid/ready handshake and buffers them in a small FIFO. Each pixel is converted to a linear framebuffer address and issued as a write on a simple write port that supports backpressure. It also provides a clear-screen sweep, so the VGA framebuffer can be erased between frames.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/pixel_writer_if.sv | 28 ++
 rtl/pixel_fifo.sv | 50 +++++
 rtl/pixel_writer.sv | 147 ++++++++++++++
 tb/tb_pixel_writer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
//   WIDTH/HEIGHT : default visible frame size
//   ADDR_W       : framebuffer address width (holds WIDTH*HEIGHT-1)
//   FIFO_DEPTH   : pixel buffer entries (power of two)
//   coord_x_t, coord_y_t, fb_addr_t, pixel_t, state_t
package fb_pkg;
  localparam int WIDTH      = 640;
  localparam int HEIGHT     = 480;
  localparam int ADDR_W     = 19;
  localparam int FIFO_DEPTH = 4;

  typedef logic [9:0]        coord_x_t;
  typedef logic [8:0]        coord_y_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    coord_x_t x;
    coord_y_t y;
    logic     color;
  } pixel_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
endpackage

// File: rtl/pixel_writer_if.sv
// Pixel stream and framebuffer write port of the pixel writer.
//   pix_valid/pix_ready/pix_x/pix_y/pix_color : incoming pixel handshake
//   mem_we/mem_addr/mem_wdata/mem_ready       : outgoing write port with backpressure
// slave  : the pixel writer (consumes pixels, drives writes)
// master : the environment (produces pixels, accepts writes)
interface pixel_writer_if;
  import fb_pkg::*;

  logic     pix_valid;
  logic     pix_ready;
  coord_x_t pix_x;
  coord_y_t pix_y;
  logic     pix_color;
  logic     mem_we;
  fb_addr_t mem_addr;
  logic     mem_wdata;
  logic     mem_ready;

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, mem_ready,
    output pix_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, mem_ready,
    input  pix_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of {x, y, color} pixels.
//   clk, reset (async active-low)
//   i_push/i_data : write side, ignored when full
//   i_pop/o_data  : read side, o_data shows the head entry, pop ignored when empty
//   o_full/o_empty: occupancy flags
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_push,
  input  pixel_t i_data,
  input  logic   i_pop,
  output pixel_t o_data,
  output logic   o_full,
  output logic   o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  pixel_t           r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_data  = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end
endmodule

// File: rtl/pixel_writer.sv
// Framebuffer-side pixel writer.
//   clk, reset (async active-low)
//   bus         : pixel handshake in, registered write port out (pixel_writer_if.slave)
//   clear_req   : one-cycle request to fill the whole frame with clear_color
//   clear_color : fill value, sampled with clear_req
//   busy        : clear pending (draining) or sweep in progress
//   drop_count  : saturating count of out-of-range pixels discarded
module pixel_writer
  import fb_pkg::*;
#(
  parameter int WIDTH  = fb_pkg::WIDTH,
  parameter int HEIGHT = fb_pkg::HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_writer_if.slave         bus,
  input  logic                  clear_req,
  input  logic                  clear_color,
  output logic                  busy,
  output logic [15:0]           drop_count
);
  localparam fb_addr_t TOTAL = fb_addr_t'(WIDTH * HEIGHT);
  localparam fb_addr_t LAST  = fb_addr_t'(WIDTH * HEIGHT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_out_en;
  logic        r_clr_color;
  fb_addr_t    r_cnt;
  logic        r_we;
  fb_addr_t    r_addr;
  logic        r_wdata;
  logic [15:0] r_drop;

  pixel_t      w_pix_in, w_head;
  logic        w_fifo_full, w_fifo_empty;
  logic        w_push, w_pop, w_out_free, w_head_oob;
  logic        w_load, w_load_data, w_drop_inc, w_cnt_inc, w_cnt_clr;
  fb_addr_t    w_load_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // For the default 640-wide frame y*640 is folded into two shifts.
  function automatic fb_addr_t pix_addr(input coord_x_t x, input coord_y_t y);
    fb_addr_t ax, ay;
    ax = fb_addr_t'(x);
    ay = fb_addr_t'(y);
    if (WIDTH == 640) return (ay << 9) + (ay << 7) + ax;
    else              return ay * fb_addr_t'(WIDTH) + ax;
  endfunction

  // r_out_en keeps pix_ready low while reset is asserted even though the
  // state register already reads IDLE.
  assign bus.pix_ready = r_out_en && (r_state == IDLE) && !w_fifo_full;
  assign w_push        = bus.pix_valid && bus.pix_ready;
  assign w_pix_in      = '{x: bus.pix_x, y: bus.pix_y, color: bus.pix_color};
  assign w_out_free    = !r_we || bus.mem_ready;
  assign w_head_oob    = (int'(w_head.x) >= WIDTH) || (int'(w_head.y) >= HEIGHT);

  assign busy          = (r_state != IDLE);
  assign drop_count    = r_drop;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_pix_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_out_en    <= 1'b0;
      r_clr_color <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_out_en <= 1'b1;
      if (r_state == IDLE && clear_req) r_clr_color <= clear_color;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + fb_addr_t'(1);
      if (w_drop_inc) r_drop <= sat_inc(r_drop);
      if (w_load) begin
        r_we    <= 1'b1;
        r_addr  <= w_load_addr;
        r_wdata <= w_load_data;
      end else if (bus.mem_ready) begin
        r_we    <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_addr = '0;
    w_load_data = 1'b0;
    w_drop_inc  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE, DRAIN: begin
        // Out-of-range heads are discarded without waiting for the output register.
        if (!w_fifo_empty) begin
          if (w_head_oob) begin
            w_pop      = 1'b1;
            w_drop_inc = 1'b1;
          end else if (w_out_free) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_load_addr = pix_addr(w_head.x, w_head.y);
            w_load_data = w_head.color;
          end
        end
        if (r_state == IDLE) begin
          if (clear_req) w_state_nxt = DRAIN;
        end else if (w_fifo_empty && w_out_free) begin
          w_state_nxt = CLEAR;
          w_cnt_clr   = 1'b1;
        end
      end
      CLEAR: begin
        if (w_out_free && (r_cnt < TOTAL)) begin
          w_load      = 1'b1;
          w_load_addr = r_cnt;
          w_load_data = r_clr_color;
          w_cnt_inc   = 1'b1;
        end
        if (r_we && bus.mem_ready && (r_addr == LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req, clear_color, busy;
  logic        s_clear_req, s_clear_color, s_busy;
  logic [15:0] drop_count, s_drop_count;
  int          checks = 0;
  int          errors = 0;
  int          exp_drop = 0;

  logic [19:0] obs_q[$], exp_q[$], sobs_q[$], sexp_q[$];

  pixel_writer_if bus();
  pixel_writer_if sbus();

  always #5 clk = ~clk;

  pixel_writer u_dut (
    .clk(clk), .reset(reset), .bus(bus), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .drop_count(drop_count)
  );

  pixel_writer #(.WIDTH(8), .HEIGHT(4)) u_small (
    .clk(clk), .reset(reset), .bus(sbus), .clear_req(s_clear_req),
    .clear_color(s_clear_color), .busy(s_busy), .drop_count(s_drop_count)
  );

  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_ready)   obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (sbus.mem_we && sbus.mem_ready) sobs_q.push_back({sbus.mem_addr, sbus.mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: an accepted pixel becomes one write at y*640+x if on screen, else a drop.
  task automatic model_big(input int x, input int y, input int c);
    if (x < 640 && y < 480) exp_q.push_back({fb_addr_t'(y * 640 + x), c[0]});
    else                    exp_drop++;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input int x, input int y, input int c);
    logic acc;
    bus.pix_x     = coord_x_t'(x);
    bus.pix_y     = coord_y_t'(y);
    bus.pix_color = c[0];
    bus.pix_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = bus.pix_ready;
      tick();
    end
    bus.pix_valid = 1'b0;
    chk("send_accept", acc, 1);
    if (acc) model_big(x, y, c);
  endtask

  initial begin
    logic acc, found, last_now, sent2;
    int   n_acc;
    reset = 1'b0;
    clear_req = 1'b0; clear_color = 1'b0;
    s_clear_req = 1'b0; s_clear_color = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_color = 1'b0; bus.mem_ready = 1'b0;
    sbus.pix_valid = 1'b0; sbus.pix_x = '0; sbus.pix_y = '0; sbus.pix_color = 1'b0; sbus.mem_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    #1 reset = 1'b1;
    tick();
    tick();
    chk("idle_pix_ready", bus.pix_ready, 1);

    // Single pixel latency
    bus.mem_ready = 1'b1;
    bus.pix_x = 10'd3; bus.pix_y = 9'd2; bus.pix_color = 1'b1; bus.pix_valid = 1'b1;
    acc = bus.pix_ready;
    tick();
    bus.pix_valid = 1'b0;
    if (acc) model_big(3, 2, 1);
    chk("lat_not_yet", bus.mem_we, 0);
    tick();
    chk("lat_we", bus.mem_we, 1);
    chk("lat_addr", bus.mem_addr, 1283);
    chk("lat_data", bus.mem_wdata, 1);
    tick();
    chk("lat_we_clear", bus.mem_we, 0);
    check_writes("single");

    // Backpressure fills FIFO and output register
    bus.mem_ready = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 12 && n_acc < 6; cyc++) begin
      bus.pix_x = coord_x_t'(n_acc); bus.pix_y = '0; bus.pix_color = 1'b1; bus.pix_valid = 1'b1;
      acc = bus.pix_ready;
      tick();
      if (acc) begin
        model_big(n_acc, 0, 1);
        n_acc++;
      end
    end
    chk("bp_accepted", n_acc, 5);
    chk("bp_ready_low", bus.pix_ready, 0);
    chk("bp_hold_we", bus.mem_we, 1);
    chk("bp_hold_addr", bus.mem_addr, 0);
    bus.mem_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("bp_stream_we", bus.mem_we, 1);
      chk("bp_stream_addr", bus.mem_addr, j);
      acc = bus.pix_ready && bus.pix_valid;
      tick();
      if (acc) begin
        model_big(5, 0, 1);
        bus.pix_valid = 1'b0;
      end
    end
    chk("bp_done_we", bus.mem_we, 0);
    check_writes("backpressure");

    // Range check
    send(640, 0, 1);
    send(0, 480, 1);
    send(639, 479, 1);
    repeat (4) tick();
    chk("range_drop", drop_count, exp_drop);
    check_writes("range");

    // Randomized pixels with random backpressure
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!bus.pix_valid && $urandom_range(0, 3) != 0) begin
        bus.pix_valid = 1'b1;
        bus.pix_x     = coord_x_t'($urandom_range(0, 700));
        bus.pix_y     = coord_y_t'($urandom_range(0, 511));
        bus.pix_color = 1'($urandom_range(0, 1));
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      acc = bus.pix_valid && bus.pix_ready;
      tick();
      if (acc) begin
        model_big(int'(bus.pix_x), int'(bus.pix_y), int'(bus.pix_color));
        bus.pix_valid = 1'b0;
      end
    end
    bus.pix_valid = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drop", drop_count, exp_drop);
    check_writes("random");

    // Full sweep on an 8x4 frame with random backpressure
    for (int a = 0; a < 32; a++) sexp_q.push_back({fb_addr_t'(a), 1'b0});
    s_clear_color = 1'b0;
    s_clear_req = 1'b1;
    tick();
    s_clear_req = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      sbus.mem_ready = ($urandom_range(0, 2) != 0);
      last_now = sbus.mem_we && sbus.mem_ready && (sbus.mem_addr == 31);
      chk("sweep_busy", s_busy, 1);
      chk("sweep_ready_low", sbus.pix_ready, 0);
      tick();
      if (last_now) begin
        found = 1'b1;
        chk("sweep_busy_fall", s_busy, 0);
      end
    end
    chk("sweep_finished", found, 1);
    chk("sweep_count", sobs_q.size(), sexp_q.size());
    for (int i = 0; i < sobs_q.size() && i < sexp_q.size(); i++) chk("sweep_write", sobs_q[i], sexp_q[i]);
    repeat (3) tick();
    chk("sweep_idle_ready", sbus.pix_ready, 1);

    // Queued pixels drain before the sweep; second request ignored; reset mid-sweep
    bus.mem_ready = 1'b0;
    send(10, 1, 1);
    send(20, 2, 0);
    send(30, 3, 1);
    clear_color = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_ready_low", bus.pix_ready, 0);
    bus.mem_ready = 1'b1;
    for (int a = 0; a < 1000; a++) exp_q.push_back({fb_addr_t'(a), 1'b1});
    found = 1'b0;
    sent2 = 1'b0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      if (bus.mem_we && bus.mem_addr == 1000) begin
        found = 1'b1;
      end else begin
        if (bus.mem_we && bus.mem_addr == 500 && !sent2) begin
          clear_req = 1'b1;
          clear_color = 1'b0;
          sent2 = 1'b1;
        end
        tick();
        clear_req = 1'b0;
      end
    end
    chk("reach_1000", found, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_we", bus.mem_we, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pix_ready", bus.pix_ready, 0);
    chk("abort_drop", drop_count, 0);
    exp_drop = 0;
    tick();
    tick();
    #3 reset = 1'b1;
    repeat (4) tick();
    chk("post_busy", busy, 0);
    chk("post_we", bus.mem_we, 0);
    chk("post_ready", bus.pix_ready, 1);
    check_writes("drain_then_sweep");
    send(7, 1, 0);
    repeat (3) tick();
    check_writes("post_reset");
    chk("post_drop", drop_count, exp_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
